start_fifo_ctrl: RTL and testbench

START_FIFO_CTRL -- requirements
Module: start_fifo_ctrl

---
 rtl/start_fifo_ctrl.sv | 86 ++++++++
 tb/tb_start_fifo_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/start_fifo_ctrl.sv
// Control logic for a start-token FIFO whose storage is an external shift register.
// Define START_FIFO_HWM_EN to build the occupancy high-water-mark tracker.
module start_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   hwm
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_empty_n;
    logic          r_full_n;
    logic          w_push;
    logic          w_pop;

    // Handshakes are qualified only by registered flags, so no read/write-to-flag path exists.
    assign w_push = if_write & if_write_ce & r_full_n;
    assign w_pop  = if_read  & if_read_ce  & r_empty_n;

    assign srl_we   = w_push;
    assign srl_din  = if_din;
    assign srl_addr = (r_count != '0) ? ADDR_WIDTH'(r_count - CW'(1)) : '0;
    assign if_dout  = srl_dout;

    assign count      = r_count;
    assign if_empty_n = r_empty_n;
    assign if_full_n  = r_full_n;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_count   <= w_count_nxt;
            r_empty_n <= (w_count_nxt != '0);
            r_full_n  <= (w_count_nxt != FULL_CNT);
        end
    end

`ifdef START_FIFO_HWM_EN
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hwm <= '0;
        end else if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign hwm = r_hwm;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_start_fifo_ctrl.sv
// Directed bench for start_fifo_ctrl with a behavioural shift-register storage model.
module tb_start_fifo_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write;
    logic          if_write_ce;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read;
    logic          if_read_ce;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          srl_we;
    logic [AW-1:0] srl_addr;
    logic [DW-1:0] srl_din;
    logic [DW-1:0] srl_dout;
    logic [AW:0]   count;
    logic [AW:0]   hwm;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [DP];

    always #5 clk = ~clk;

    start_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_write   (if_write),
        .if_write_ce(if_write_ce),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_read    (if_read),
        .if_read_ce (if_read_ce),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .srl_we     (srl_we),
        .srl_addr   (srl_addr),
        .srl_din    (srl_din),
        .srl_dout   (srl_dout),
        .count      (count),
        .hwm        (hwm)
    );

    // Shift-register storage: index 0 receives new data, older entries move up.
    always @(posedge clk) begin
        if (srl_we) begin
            for (int i = DP - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= srl_din;
        end
    end
    assign srl_dout = mem[srl_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic rst);
        if_write = wr;
        if_din   = d;
        if_read  = rd;
        reset    = rst;
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
        reset    = 1'b0;
    endtask

    logic [AW:0] hwm_exp6;

    initial begin
        if_write = 1'b0; if_write_ce = 1'b1; if_din = '0;
        if_read = 1'b0; if_read_ce = 1'b1; reset = 1'b1;
`ifdef START_FIFO_HWM_EN
        hwm_exp6 = 4'd6;
`else
        hwm_exp6 = 4'd0;
`endif
        for (int i = 0; i < DP; i++) mem[i] = '0;
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        check("rst_count", 32'(count), 0);
        check("rst_empty_n", 32'(if_empty_n), 0);
        check("rst_full_n", 32'(if_full_n), 1);
        check("rst_hwm", 32'(hwm), 0);

        // Reads on empty and writes with ce low are ignored.
        step(0, 8'h00, 1, 0);
        check("empty_pop_count", 32'(count), 0);
        if_write_ce = 1'b0;
        step(1, 8'h55, 0, 0);
        if_write_ce = 1'b1;
        check("ce_low_count", 32'(count), 0);

        // Three pushes 1,0,1.
        step(1, 8'h01, 0, 0);
        check("p1_empty_n", 32'(if_empty_n), 1);
        check("p1_dout", 32'(if_dout), 32'h01);
        step(1, 8'h00, 0, 0);
        step(1, 8'h01, 0, 0);
        check("p3_count", 32'(count), 3);
        check("p3_dout", 32'(if_dout), 32'h01);
        step(0, 8'h00, 1, 0);
        check("pop1_dout", 32'(if_dout), 32'h00);
        step(0, 8'h00, 1, 0);
        check("pop2_dout", 32'(if_dout), 32'h01);
        step(0, 8'h00, 1, 0);
        check("drain_empty_n", 32'(if_empty_n), 0);
        check("drain_count", 32'(count), 0);

        // Fill to full, then a ninth write.
        for (int i = 0; i < 8; i++) step(1, DW'(8'h10 + i), 0, 0);
        check("full_count", 32'(count), 8);
        check("full_full_n", 32'(if_full_n), 0);
        step(1, 8'hAA, 0, 0);
        check("w9_count", 32'(count), 8);
        check("w9_dout", 32'(if_dout), 32'h10);

        // Full with push+pop: only the pop lands.
        step(1, 8'hBB, 1, 0);
        check("fpp_count", 32'(count), 7);
        check("fpp_full_n", 32'(if_full_n), 1);
        check("fpp_dout", 32'(if_dout), 32'h11);

        // Steady-state push+pop at occupancy 4.
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step(1, DW'(8'h20 + i), 0, 0);
        for (int k = 0; k < 10; k++) begin
            check("pp_order", 32'(if_dout), 32'(8'h20 + k));
            step(1, DW'(8'h24 + k), 1, 0);
        end
        check("pp_count", 32'(count), 4);
        check("pp_addr", 32'(srl_addr), 3);
        check("pp_dout", 32'(if_dout), 32'h2A);

        // High-water mark: fill to 6, drain to 0.
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) step(1, DW'(8'h30 + i), 0, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);
        check("hwm_count", 32'(count), 0);
        check("hwm_value", 32'(hwm), 32'(hwm_exp6));

        // Reset with a simultaneous push at occupancy 5.
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(1, DW'(8'h40 + i), 0, 0);
        check("pre_rst_count", 32'(count), 5);
        step(1, 8'h99, 0, 1);
        check("rp_count", 32'(count), 0);
        check("rp_empty_n", 32'(if_empty_n), 0);
        check("rp_full_n", 32'(if_full_n), 1);
        check("rp_hwm", 32'(hwm), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
